led_bank_arbiter: RTL
=====================

Name: led_bank_arbiter

Overview:
- Shares the board's 8-bit LED bank between four requesters (e.g. switch echo, counter display, status, test pattern).
- Round-robin arbitration; each winner owns the bank for a fixed dwell time.
- Snapshots the winner's pattern and applies global PWM brightness.
- Drives the LED output stage directly; sits between the requester logic and the LED pins.

Parameters:
LED_W, 8, LED bank width.
DWELL_CYCLES, 25_000_000, clock cycles a grant is held; must be >= 2.
CNT_W, $clog2(DWELL_CYCLES), dwell counter width (derived, not overridden).

Ports:
clk  input  1  system clock, all logic rising-edge.
rst_n  input  1  asynchronous active-low reset.
req  input  4  request per requester, level; held until ack or voluntary drop.
pat_in  input  4*LED_W  requester patterns; requester i at bits [i*LED_W +: LED_W].
duty  input  4  global brightness, 0 = off, 15 = full on.
grant  output  4  one-hot current owner, 0 when idle.
ack  output  4  one-cycle pulse to requester whose dwell completed.
busy  output  1  high while a grant is active.
led_out  output  LED_W  registered LED drive.

Behaviour:
- Reset (async assert, sync release):
  - grant, ack, led_out = 0; busy = 0.
  - Internal pattern register = 0; PWM counter = 0.
  - Round-robin pointer last = 3, so requester 0 has top priority first.
  - Reset mid-dwell aborts immediately, with no ack.
- FSM states IDLE, DWELL.
- IDLE:
  - Any req bit high at edge t: winner = first set bit scanning last+1, last+2, ... modulo 4.
  - At edge t: grant = onehot(winner), pattern register = pat_in slice of winner, counter = DWELL_CYCLES-1, last = winner, go to DWELL.
  - Grant is therefore visible the cycle after req is first seen.
- DWELL:
  - Counter decrements each cycle, so grant is high for exactly DWELL_CYCLES cycles.
  - Terminal (counter == 0) at edge: ack[owner] = 1 for one cycle.
    - If any req is high (including the old owner), re-arbitrate the same edge. Back-to-back grant, no gap. The old owner is lowest priority because last was updated.
    - Otherwise grant = 0, pattern register = 0, go to IDLE.
  - Early release: if req[owner] is low at any edge before terminal, release that edge with no ack, then re-arbitrate or go IDLE as above.
  - Early release takes precedence if it coincides with terminal: no ack.
  - Pattern is a snapshot; pat_in changes during dwell are ignored.
- ack: never asserted for more than one cycle; never two bits at once.
- busy = (state == DWELL).
- PWM:
  - 4-bit free-running counter pwm_cnt, wraps 15 -> 0.
  - on = (duty == 15) or (pwm_cnt < duty).
  - led_out registered: led_out <= on ? pattern_reg : 0.
  - led_out lags grant/pattern load by one cycle.
- duty is sampled live every cycle (no snapshot).
- req bits that are not one-hot are normal; only the round-robin scan order decides.

Test Plan (DWELL_CYCLES=4, duty=15 unless stated):
1. Single request, cycle numbering from the edge where req is first sampled:
   - Stimulus: req=0001, pat0=0xA5 at cycle 0, held.
   - Response: grant=0001 cycles 1-4; led_out=0xA5 cycles 2-5.
   - Response: ack=0001 in cycle 5, with grant re-issued 0001 in cycle 5. Releasing req at ack gives grant=0 in cycle 6 and led_out=0x00 in cycle 7.
2. Round robin:
   - Stimulus: req=1111 held, patterns 0x01/0x02/0x04/0x08.
   - Response: grant sequence 0001, 0010, 0100, 1000, 0001, each exactly 4 cycles, back-to-back.
   - Response: ack pulses to 0001, 0010, 0100, 1000 on each handover cycle; busy stays 1.
3. Early release:
   - Stimulus: req=0100 granted at cycle 1; req drops at cycle 2.
   - Response: grant=0 from cycle 3; ack never pulses; busy=0 from cycle 3.
4. Snapshot and coincident events:
   - Stimulus: pat0 changes 0x3C -> 0xFF during dwell.
   - Response: led_out stays 0x3C.
   - Stimulus: req0 dropped exactly on the terminal cycle.
   - Response: no ack.
5. PWM:
   - duty=4, req held: led_out = pattern for 4 of every 16 cycles, 0 otherwise.
   - duty=0: led_out always 0.
   - duty=15: constant pattern.
6. Reset mid-dwell:
   - Stimulus: assert rst_n=0 asynchronously at cycle 2 of a grant.
   - Response: grant, ack, busy, led_out = 0 without a clock edge.
   - After release with req=1111: requester 0 is granted first.

Source files
------------

// File: rtl/led_bank_arbiter_if.sv
// LED bank arbiter bus: requester side (master) and arbiter side (slave).
interface led_bank_arbiter_if #(
   parameter int unsigned LED_W = 8
);
   logic [3:0]         req;
   logic [4*LED_W-1:0] pat_in;
   logic [3:0]         duty;
   logic [3:0]         grant;
   logic [3:0]         ack;
   logic               busy;
   logic [LED_W-1:0]   led_out;

   modport master (
      output req, pat_in, duty,
      input  grant, ack, busy, led_out
   );

   modport slave (
      input  req, pat_in, duty,
      output grant, ack, busy, led_out
   );
endinterface

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the shared LED bank. Each winner holds the bank for a
// fixed dwell, its pattern is snapshotted at grant time and shown through a
// global 4-bit PWM brightness stage.
module led_bank_arbiter #(
   parameter int unsigned LED_W        = 8,
   parameter int unsigned DWELL_CYCLES = 25_000_000
) (
   input logic            clk,
   input logic            rst_n,
   led_bank_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StDwell} state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [1:0]         last_q;
   logic [LED_W-1:0]   pat_q;
   logic [3:0]         grant_q;
   logic [3:0]         ack_q;
   logic               busy_q;
   logic [3:0]         pwm_q;
   logic [LED_W-1:0]   led_q;

   logic               win_valid;
   logic [1:0]         win_idx;
   logic [1:0]         scan_idx;
   logic               dwell_end;
   logic               start;
   logic               owner_req;
   logic               pwm_on;

   // Round-robin scan from last+1; the downward loop lets the nearest hit win.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = 2'd0;
      scan_idx  = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         scan_idx = last_q + 2'(k);
         if (bus.req[scan_idx]) begin
            win_valid = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   // Dwell ends on early release (owner dropped req) or counter terminal;
   // while dwelling the owner is always last_q.
   always_comb begin
      owner_req = bus.req[last_q];
      dwell_end = (state_q == StDwell) && (!owner_req || (cnt_q == '0));
      start     = win_valid && ((state_q == StIdle) || dwell_end);
      pwm_on    = (bus.duty == 4'hF) || (pwm_q < bus.duty);
   end

   // Arbitration FSM with registered grant/ack/busy and pattern snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         last_q  <= 2'd3;
         pat_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         // Ack only when the dwell ran to terminal; release wins a tie.
         ack_q <= (dwell_end && owner_req) ? (4'b0001 << last_q) : 4'b0000;
         if (start) begin
            state_q <= StDwell;
            busy_q  <= 1'b1;
            grant_q <= 4'b0001 << win_idx;
            pat_q   <= bus.pat_in[win_idx*LED_W +: LED_W];
            cnt_q   <= CNT_LOAD;
            last_q  <= win_idx;
         end else if (dwell_end) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            grant_q <= '0;
            pat_q   <= '0;
         end else if (state_q == StDwell) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   // Free-running PWM counter and registered LED drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_q <= '0;
         led_q <= '0;
      end else begin
         pwm_q <= pwm_q + 4'd1;
         led_q <= pwm_on ? pat_q : '0;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.ack     = ack_q;
   assign bus.busy    = busy_q;
   assign bus.led_out = led_q;

endmodule
